// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder datapath: controller state encoding,
// default operand width and the bit-counter width helper.
package serial_adder_pkg;

  localparam int unsigned DefaultWidth = 8;

  // 2-bit encoding shared with the adder's load/enable controller; 2'b11 is illegal.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_HOLD    = 2'b10
  } state_e;

  // Bits needed to count 0..w-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned w);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < w) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Frame bit counter with synchronous clear, increment and terminal-count flag.
module bit_counter
  import serial_adder_pkg::*;
#(
  parameter int unsigned  Width = DefaultWidth,
  localparam int unsigned CntW  = cnt_width(Width)
) (
  input  logic            clk,
  input  logic            Mrst,
  input  logic            clr,
  input  logic            inc,
  output logic [CntW-1:0] count,
  output logic            last
);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge Mrst) begin
    if (!Mrst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CntW'(Width - 1));

endmodule

// File: rtl/serial_sum_collector.sv
// Reassembles the LSB-first serial sum and final carry into a parallel result
// held under a valid/ack handshake.
module serial_sum_collector
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic           clk,
  input  logic           Mrst,
  input  logic           start,
  input  logic           bit_in,
  input  logic           bit_valid,
  input  logic           carry_in,
  output logic [WIDTH:0] result,
  output logic           result_valid,
  input  logic           result_ack,
  output logic           busy,
  output logic           aborted
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [WIDTH:0]     result_q, result_d;
  logic               aborted_q, aborted_d;
  logic               cnt_clr, cnt_inc, cnt_last;
  logic [CntW-1:0]    cnt;
  logic               unused_sreg_lsb;
  logic               unused_cnt;

  bit_counter #(
    .Width (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .Mrst  (Mrst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (cnt),
    .last  (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    result_d  = result_q;
    aborted_d = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_clr = 1'b1;
          sreg_d  = '0;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (start) begin
          // Restart wins over a coincident bit.
          cnt_clr   = 1'b1;
          sreg_d    = '0;
          aborted_d = 1'b1;
        end else if (bit_valid) begin
          sreg_d = {bit_in, sreg_q[WIDTH-1:1]};
          if (cnt_last) begin
            result_d = {carry_in, bit_in, sreg_q[WIDTH-1:1]};
            cnt_clr  = 1'b1;
            state_d  = ST_HOLD;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (result_ack) begin
          if (start) begin
            cnt_clr = 1'b1;
            sreg_d  = '0;
            state_d = ST_COLLECT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Mrst) begin
    if (!Mrst) begin
      state_q   <= ST_IDLE;
      sreg_q    <= '0;
      result_q  <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      result_q  <= result_d;
      aborted_q <= aborted_d;
    end
  end

  assign result       = result_q;
  assign result_valid = (state_q == ST_HOLD);
  assign busy         = (state_q == ST_COLLECT);
  assign aborted      = aborted_q;

  // The oldest bit is shifted out on the completing edge; count is for observation only.
  assign unused_sreg_lsb = sreg_q[0];
  assign unused_cnt      = ^cnt;

endmodule

// File: tb/tb_serial_sum_collector.sv
// Randomized and directed bench for serial_sum_collector against a queue-based
// frame model.
module tb_serial_sum_collector;

  localparam int unsigned W = 8;

  logic         clk;
  logic         Mrst;
  logic         start;
  logic         bit_in;
  logic         bit_valid;
  logic         carry_in;
  logic [W:0]   result;
  logic         result_valid;
  logic         result_ack;
  logic         busy;
  logic         aborted;

  int n_tests;
  int n_fail;

  // Reference model: phase 0 idle, 1 collecting, 2 holding a result.
  int         m_phase;
  logic       m_bits[$];
  logic [W:0] m_result;
  logic       m_aborted;

  serial_sum_collector #(
    .WIDTH (W)
  ) dut (
    .clk          (clk),
    .Mrst         (Mrst),
    .start        (start),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .carry_in     (carry_in),
    .result       (result),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .busy         (busy),
    .aborted      (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W:0] frame_value(input logic c);
    logic [W:0] v;
    v = '0;
    for (int i = 0; i < W; i++) v[i] = m_bits[i];
    v[W] = c;
    return v;
  endfunction

  task automatic model_edge();
    m_aborted = 1'b0;
    case (m_phase)
      0: if (start) begin
        m_bits.delete();
        m_phase = 1;
      end
      1: if (start) begin
        m_bits.delete();
        m_aborted = 1'b1;
      end else if (bit_valid) begin
        m_bits.push_back(bit_in);
        if (m_bits.size() == W) begin
          m_result = frame_value(carry_in);
          m_bits.delete();
          m_phase = 2;
        end
      end
      default: if (result_ack) begin
        m_bits.delete();
        m_phase = start ? 1 : 0;
      end
    endcase
  endtask

  task automatic check_outputs();
    check_eq("result", 32'(result), 32'(m_result));
    check_eq("result_valid", 32'(result_valid), 32'(m_phase == 2));
    check_eq("busy", 32'(busy), 32'(m_phase == 1));
    check_eq("aborted", 32'(aborted), 32'(m_aborted));
    check_eq("cnt_range", 32'(dut.cnt < W), 32'd1);
  endtask

  task automatic step(input logic s, input logic bv, input logic bi, input logic ci,
                      input logic ack);
    @(negedge clk);
    start      = s;
    bit_valid  = bv;
    bit_in     = bi;
    carry_in   = ci;
    result_ack = ack;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    Mrst = 1'b0;
    #1;
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_valid", 32'(result_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_aborted", 32'(aborted), 32'd0);
    m_phase   = 0;
    m_bits.delete();
    m_result  = '0;
    m_aborted = 1'b0;
    start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; carry_in = 1'b0; result_ack = 1'b0;
    @(negedge clk);
    Mrst = 1'b1;
  endtask

  // Start pulse followed by WIDTH bits; optional idle cycle with junk data before each bit.
  task automatic send_frame(input logic [W-1:0] data, input logic c, input bit gaps);
    step(1'b1, 1'b1, $urandom_range(1), 1'b0, 1'b0);
    for (int i = 0; i < W; i++) begin
      if (gaps) step(1'b0, 1'b0, $urandom_range(1), $urandom_range(1), 1'b0);
      step(1'b0, 1'b1, data[i], (i == W - 1) ? c : 1'($urandom_range(1)), 1'b0);
    end
  endtask

  task automatic ack_only();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_phase = 0;
    m_result = '0;
    m_aborted = 1'b0;
    Mrst = 1'b0;
    start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; carry_in = 1'b0; result_ack = 1'b0;
    #3;
    check_eq("init_result", 32'(result), 32'd0);
    check_eq("init_valid", 32'(result_valid), 32'd0);
    check_eq("init_busy", 32'(busy), 32'd0);
    @(negedge clk);
    Mrst = 1'b1;

    // Basic frame
    send_frame(8'hA5, 1'b1, 1'b0);
    check_eq("basic", 32'(result), 32'h1A5);
    ack_only();

    // Gapped stream
    send_frame(8'h3C, 1'b0, 1'b1);
    check_eq("gapped", 32'(result), 32'h03C);
    ack_only();

    // Restart after three bits
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0);
    check_eq("restart", 32'(result), 32'h0FF);

    // HOLD protection, then ack with start for a back-to-back frame
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(1)), 1'b1, 1'b1, 1'b0);
    check_eq("hold_kept", 32'(result), 32'h0FF);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < W; i++) step(1'b0, 1'b1, (i == 0), 1'b1, 1'b0);
    check_eq("b2b", 32'(result), 32'h101);
    ack_only();

    // Async reset mid-frame
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    send_frame(8'h80, 1'b0, 1'b0);
    check_eq("after_rst", 32'(result), 32'h080);
    ack_only();

    // Boundaries
    send_frame(8'h00, 1'b1, 1'b0);
    check_eq("zeros", 32'(result), 32'h100);
    ack_only();
    send_frame(8'hFF, 1'b1, 1'b0);
    check_eq("ones", 32'(result), 32'h1FF);
    ack_only();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) begin
        do_reset();
      end else begin
        step(($urandom % 16) == 0, ($urandom % 3) != 0, 1'($urandom_range(1)),
             1'($urandom_range(1)), ($urandom % 4) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
